reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard_pkg.sv | 24 ++
 rtl/reg_scoreboard_sb_counter.sv | 52 +++++
 rtl/reg_scoreboard.sv | 127 ++++++++++++
 tb/tb_reg_scoreboard.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared constants and helpers for the register scoreboard slice.
//   REG_IDX_LEN   : width of a register index (R0..R14 plus PC at 15)
//   NUM_ARCH_REGS : number of tracked general registers
//   PC_IDX        : index of the program counter, never tracked
//   SB_CNT_W      : width of each per-register pending-write counter
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

  localparam int         REG_IDX_LEN   = 4;
  localparam int         NUM_ARCH_REGS = 15;
  localparam logic [3:0] PC_IDX        = 4'd15;
  localparam int         SB_CNT_W      = 2;

  typedef logic [REG_IDX_LEN-1:0] reg_idx_t;

  // The PC slot is written through a separate path, so it never takes part
  // in hazard tracking.
  function automatic logic is_tracked(input reg_idx_t idx);
    return idx != PC_IDX;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// Saturating up/down pending-write counter for one register.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (clears the count)
//   inc      : one more write issued to this register
//   dec      : one write retiring (ignored while the count is already zero)
//   cnt      : current count
//   cnt_next : count that will be loaded at the next rising edge
//   zero     : count is zero
//   full     : count is at its maximum
// -----------------------------------------------------------------------------
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             zero,
  output logic             full
);

  logic [CNT_W-1:0] cnt_reg;
  logic             dec_eff;

  assign zero    = (cnt_reg == '0);
  assign full    = (cnt_reg == {CNT_W{1'b1}});
  // A retirement against an empty counter is an error condition handled by
  // the parent; here it simply has no effect.
  assign dec_eff = dec && !zero;

  always_comb begin
    cnt_next = cnt_reg;
    if (inc && !dec_eff && !full)
      cnt_next = cnt_reg + CNT_W'(1);
    else if (dec_eff && !inc)
      cnt_next = cnt_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Tracks in-flight writes to R0..R14 between decode issue and write-back and
// produces a combinational decode stall for read-after-write hazards and for
// destinations whose pending-write counter is full.
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   issue_valid       : decode presents an instruction
//   issue_wb_en       : that instruction writes issue_dest
//   issue_dest        : destination index (15 = PC, untracked)
//   src1/src2         : source indices, qualified by src1_used/src2_used
//   flush             : kill the presented instruction
//   wb_en, dest_wb    : write-back this cycle and its index
//   hazard            : stall decode (combinational)
//   issue_accept      : presented write counted this cycle (combinational)
//   busy_mask         : registered, bit i set when counter i is nonzero
//   pending_any       : registered OR of busy_mask
//   underflow_err     : sticky, write-back hit an empty counter
// -----------------------------------------------------------------------------
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int CNT_W    = SB_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  logic [3:0]          issue_dest,
  input  logic [3:0]          src1,
  input  logic [3:0]          src2,
  input  logic                src1_used,
  input  logic                src2_used,
  input  logic                flush,
  input  logic                wb_en,
  input  logic [3:0]          dest_wb,
  output logic                hazard,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                pending_any,
  output logic                underflow_err
);

  localparam int IDX_SPAN = 1 << REG_IDX_LEN;

  logic [CNT_W-1:0]    cnt_cur  [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt  [NUM_REGS];
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] cnt_zero;
  logic [NUM_REGS-1:0] cnt_full;
  logic [NUM_REGS-1:0] eff_nz;
  logic [NUM_REGS-1:0] eff_full;
  logic [NUM_REGS-1:0] busy_next;

  // Index-wide copies padded with zeros so a lookup at the PC slot is always
  // in range; every such lookup is also gated by is_tracked().
  logic [IDX_SPAN-1:0] eff_nz_ext;
  logic [IDX_SPAN-1:0] eff_full_ext;
  logic [IDX_SPAN-1:0] zero_ext;

  logic src_hz1, src_hz2, dest_full, live_issue, underflow_hit;

  logic [NUM_REGS-1:0] busy_mask_reg;
  logic                pending_any_reg;
  logic                underflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wb_hit[gi]  = wb_en && (dest_wb == reg_idx_t'(gi));
      assign inc_vec[gi] = issue_accept && (issue_dest == reg_idx_t'(gi));

      // Effective count seen by decode: the register file writes through on
      // the same cycle, so a retiring write no longer blocks readers. A
      // retirement against an empty counter saturates at zero.
      assign eff_nz[gi]   = !cnt_zero[gi] &&
                            !(wb_hit[gi] && (cnt_cur[gi] == CNT_W'(1)));
      assign eff_full[gi] = cnt_full[gi] && !wb_hit[gi];

      assign busy_next[gi] = (cnt_nxt[gi] != '0);

      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc_vec[gi]),
        .dec      (wb_hit[gi]),
        .cnt      (cnt_cur[gi]),
        .cnt_next (cnt_nxt[gi]),
        .zero     (cnt_zero[gi]),
        .full     (cnt_full[gi])
      );
    end
  endgenerate

  assign eff_nz_ext   = {{(IDX_SPAN-NUM_REGS){1'b0}}, eff_nz};
  assign eff_full_ext = {{(IDX_SPAN-NUM_REGS){1'b0}}, eff_full};
  assign zero_ext     = {{(IDX_SPAN-NUM_REGS){1'b0}}, cnt_zero};

  assign src_hz1   = src1_used && is_tracked(src1) && eff_nz_ext[src1];
  assign src_hz2   = src2_used && is_tracked(src2) && eff_nz_ext[src2];
  assign dest_full = issue_wb_en && is_tracked(issue_dest) && eff_full_ext[issue_dest];

  // Flush wins: a killed instruction neither stalls nor counts.
  assign live_issue   = issue_valid && !flush;
  assign hazard       = live_issue && (src_hz1 || src_hz2 || dest_full);
  assign issue_accept = live_issue && !hazard && issue_wb_en && is_tracked(issue_dest);

  assign underflow_hit = wb_en && is_tracked(dest_wb) && zero_ext[dest_wb];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_mask_reg   <= '0;
      pending_any_reg <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      busy_mask_reg   <= busy_next;
      pending_any_reg <= |busy_next;
      underflow_reg   <= underflow_reg | underflow_hit;
    end
  end

  assign busy_mask     = busy_mask_reg;
  assign pending_any   = pending_any_reg;
  assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed bench for reg_scoreboard. Inputs change 1 time unit after a rising
// edge; combinational outputs are sampled 1 unit later, registered outputs
// 1 unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_wb_en, src1_used, src2_used, flush, wb_en;
  logic [3:0]  issue_dest, src1, src2, dest_wb;
  logic        hazard, issue_accept, pending_any, underflow_err;
  logic [14:0] busy_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_wb_en   (issue_wb_en),
    .issue_dest    (issue_dest),
    .src1          (src1),
    .src2          (src2),
    .src1_used     (src1_used),
    .src2_used     (src2_used),
    .flush         (flush),
    .wb_en         (wb_en),
    .dest_wb       (dest_wb),
    .hazard        (hazard),
    .issue_accept  (issue_accept),
    .busy_mask     (busy_mask),
    .pending_any   (pending_any),
    .underflow_err (underflow_err)
  );

  task automatic idle();
    issue_valid = 0; issue_wb_en = 0; issue_dest = 0;
    src1 = 0; src2 = 0; src1_used = 0; src2_used = 0;
    flush = 0; wb_en = 0; dest_wb = 0;
  endtask

  // Present an issue/write-back combination and let it settle.
  task automatic present(input logic v, input logic we, input logic [3:0] d,
                         input logic [3:0] s1, input logic u1,
                         input logic fl, input logic wbe, input logic [3:0] wbd);
    issue_valid = v; issue_wb_en = we; issue_dest = d;
    src1 = s1; src1_used = u1; src2 = 0; src2_used = 0;
    flush = fl; wb_en = wbe; dest_wb = wbd;
    #1;
  endtask

  // Commit the presented cycle, then return inputs to idle.
  task automatic step();
    @(posedge clk); #1;
    $display("t=%0t txn v=%0b we=%0b d=%0d s1=%0d fl=%0b wb=%0b/%0d -> busy=%h pend=%0b uf=%0b",
             $time, issue_valid, issue_wb_en, issue_dest, src1, flush, wb_en, dest_wb,
             busy_mask, pending_any, underflow_err);
    idle();
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #3;
    checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy_mask); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", pending_any); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow_err); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b exp 0", hazard); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_issue_basic(input string tag);
    present(1, 1, 4'd3, 4'd0, 0, 0, 0, 4'd0);
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL %s_accept got %b exp 1", tag, issue_accept); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL %s_hazard got %b exp 0", tag, hazard); end
    checks++; if (busy_mask !== 15'h0000) begin errors++; $display("FAIL %s_busy_before got %h exp 0000", tag, busy_mask); end
    step();
    checks++; if (busy_mask !== 15'h0008) begin errors++; $display("FAIL %s_busy got %h exp 0008", tag, busy_mask); end
    checks++; if (pending_any !== 1'b1) begin errors++; $display("FAIL %s_pending got %b exp 1", tag, pending_any); end
  endtask

  // cnt[3]=1 on entry, 0 on exit.
  task automatic test_read_hazard();
    present(1, 0, 4'd0, 4'd3, 1, 0, 0, 4'd0);
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL raw_hazard got %b exp 1", hazard); end
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL raw_accept got %b exp 0", issue_accept); end
    // Write-through: same read plus retire of R3, and re-issue to R3.
    present(1, 1, 4'd3, 4'd3, 1, 0, 1, 4'd3);
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL wt_hazard got %b exp 0", hazard); end
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL wt_accept got %b exp 1", issue_accept); end
    step();
    checks++; if (busy_mask !== 15'h0008) begin errors++; $display("FAIL wt_busy_same got %h exp 0008", busy_mask); end
    // Retire R3 again while a non-writing reader uses it.
    present(1, 0, 4'd0, 4'd3, 1, 0, 1, 4'd3);
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL wt2_hazard got %b exp 0", hazard); end
    step();
    checks++; if (busy_mask !== 15'h0000) begin errors++; $display("FAIL wt2_busy got %h exp 0000", busy_mask); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL wt2_pending got %b exp 0", pending_any); end
  endtask

  task automatic test_dest_full();
    for (int k = 0; k < 3; k++) begin
      present(1, 1, 4'd5, 4'd0, 0, 0, 0, 4'd0);
      checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL fill%0d_accept got %b exp 1", k, issue_accept); end
      step();
    end
    checks++; if (busy_mask !== 15'h0020) begin errors++; $display("FAIL fill_busy got %h exp 0020", busy_mask); end
    present(1, 1, 4'd5, 4'd0, 0, 0, 0, 4'd0);
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL full_hazard got %b exp 1", hazard); end
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL full_accept got %b exp 0", issue_accept); end
    present(1, 1, 4'd5, 4'd0, 0, 0, 1, 4'd5);
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL full_wb_hazard got %b exp 0", hazard); end
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL full_wb_accept got %b exp 1", issue_accept); end
    step();
    // Count must still be exactly 3: busy through two retirements, clear on the third.
    for (int k = 0; k < 3; k++) begin
      present(0, 0, 4'd0, 4'd0, 0, 0, 1, 4'd5);
      step();
      checks++;
      if (busy_mask !== ((k < 2) ? 15'h0020 : 15'h0000)) begin
        errors++; $display("FAIL drain%0d_busy got %h exp %h", k, busy_mask, (k < 2) ? 15'h0020 : 15'h0000);
      end
    end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL drain_underflow got %b exp 0", underflow_err); end
  endtask

  task automatic test_flush_pc();
    present(1, 1, 4'd2, 4'd0, 0, 0, 0, 4'd0);
    step();
    present(1, 1, 4'd4, 4'd2, 1, 1, 0, 4'd0);
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL flush_hazard got %b exp 0", hazard); end
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL flush_accept got %b exp 0", issue_accept); end
    step();
    checks++; if (busy_mask !== 15'h0004) begin errors++; $display("FAIL flush_busy got %h exp 0004", busy_mask); end
    present(1, 1, 4'd15, 4'd15, 1, 0, 1, 4'd15);
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL pc_hazard got %b exp 0", hazard); end
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL pc_accept got %b exp 0", issue_accept); end
    step();
    checks++; if (busy_mask !== 15'h0004) begin errors++; $display("FAIL pc_busy got %h exp 0004", busy_mask); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL pc_underflow got %b exp 0", underflow_err); end
    present(0, 0, 4'd0, 4'd0, 0, 0, 1, 4'd2);
    step();
    checks++; if (busy_mask !== 15'h0000) begin errors++; $display("FAIL flush_drain_busy got %h exp 0000", busy_mask); end
  endtask

  task automatic test_underflow();
    present(0, 0, 4'd0, 4'd0, 0, 0, 1, 4'd7);
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL uf_early got %b exp 0", underflow_err); end
    step();
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_set got %b exp 1", underflow_err); end
    checks++; if (busy_mask !== 15'h0000) begin errors++; $display("FAIL uf_busy got %h exp 0000", busy_mask); end
    present(1, 1, 4'd2, 4'd0, 0, 0, 0, 4'd0);
    step();
    present(0, 0, 4'd0, 4'd0, 0, 0, 1, 4'd2);
    step();
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", underflow_err); end
  endtask

  task automatic test_async_reset();
    present(1, 1, 4'd1, 4'd0, 0, 0, 0, 4'd0); step();
    present(1, 1, 4'd1, 4'd0, 0, 0, 0, 4'd0); step();
    present(1, 1, 4'd9, 4'd0, 0, 0, 0, 4'd0); step();
    checks++; if (busy_mask !== 15'h0202) begin errors++; $display("FAIL load_busy got %h exp 0202", busy_mask); end
    present(1, 0, 4'd0, 4'd1, 1, 0, 0, 4'd0);
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL pre_rst_hazard got %b exp 1", hazard); end
    #2 rst = 1;
    #1;
    checks++; if (busy_mask !== 15'h0) begin errors++; $display("FAIL arst_busy got %h exp 0000", busy_mask); end
    checks++; if (pending_any !== 1'b0) begin errors++; $display("FAIL arst_pending got %b exp 0", pending_any); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL arst_underflow got %b exp 0", underflow_err); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL arst_hazard got %b exp 0", hazard); end
    idle();
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
  endtask

  // cnt[3]=1 on entry: issue to R6 reading R3 while R3 retires.
  task automatic test_back_to_back();
    present(1, 1, 4'd6, 4'd3, 1, 0, 0, 4'd0);
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b exp 1", hazard); end
    present(1, 1, 4'd6, 4'd3, 1, 0, 1, 4'd3);
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", issue_accept); end
    step();
    checks++; if (busy_mask !== 15'h0040) begin errors++; $display("FAIL b2b_busy got %h exp 0040", busy_mask); end
  endtask

  initial begin
    test_reset();
    test_issue_basic("issue");
    test_read_hazard();
    test_dest_full();
    test_flush_pc();
    test_underflow();
    test_async_reset();
    test_issue_basic("post_rst");
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
